// File: rtl/branch_pkg.sv
// Shared branch types: predictor counter encoding, conditional-branch funct3
// codes, and saturating counter helpers.
package branch_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_t;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } branch_t;

  localparam bp_ctr_t BP_CTR_RESET = WNT;

  function automatic bp_ctr_t sat_inc(input bp_ctr_t c);
    return (c == ST) ? ST : bp_ctr_t'(c + 2'd1);
  endfunction

  function automatic bp_ctr_t sat_dec(input bp_ctr_t c);
    return (c == SNT) ? SNT : bp_ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/bp_ghr.sv
// Global branch history shift register for the gshare build (BP_GSHARE_EN).
// Shifts in each resolved direction; updates are resolve-time, never speculative.
module bp_ghr #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             taken,
  output logic [WIDTH-1:0] ghr
);

  logic [WIDTH-1:0] ghr_q, ghr_d;

  always_comb begin
    ghr_d = shift_en ? {ghr_q[WIDTH-2:0], taken} : ghr_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) ghr_q <= '0;
    else     ghr_q <= ghr_d;
  end

  assign ghr = ghr_q;

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage 2-bit direction predictor with tagged BTB; combinational lookup,
// training one edge after execute resolves. Gshare indexing under BP_GSHARE_EN.
module branch_predictor
  import branch_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned TAG_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XLEN-1:0]       pc_f,
  output logic                  predict_taken_f,
  output logic [XLEN-1:0]       predict_target_f,
  output logic [INDEX_BITS-1:0] pred_index_f,
  input  logic                  update_en_e,
  input  logic [XLEN-1:0]       update_pc_e,
  input  logic [INDEX_BITS-1:0] update_index_e,
  input  logic                  update_taken_e,
  input  logic [XLEN-1:0]       update_target_e
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  localparam int unsigned TAG_LO  = INDEX_BITS + 2;
  localparam int unsigned TAG_HI  = INDEX_BITS + TAG_BITS + 1;

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  bp_ctr_t             ctr_q    [ENTRIES];

  logic [INDEX_BITS-1:0] look_idx;
  logic [TAG_BITS-1:0]   look_tag, upd_tag;
  logic                  look_hit, upd_hit;

  logic                  wr_en;
  bp_ctr_t               wr_ctr_d;
  logic [XLEN-1:0]       wr_target_d;

  // Address bits outside the index/tag fields never reach the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_f[1:0], pc_f[XLEN-1:TAG_HI+1],
                            update_pc_e[TAG_LO-1:0], update_pc_e[XLEN-1:TAG_HI+1]};

`ifdef BP_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr;

  bp_ghr #(.WIDTH(INDEX_BITS)) u_ghr (
    .clk      (clk),
    .rst      (rst),
    .shift_en (update_en_e),
    .taken    (update_taken_e),
    .ghr      (ghr)
  );

  assign look_idx = pc_f[INDEX_BITS+1:2] ^ ghr;
`else
  assign look_idx = pc_f[INDEX_BITS+1:2];
`endif

  // Lookup reads registered state only, so a same-cycle update is not visible.
  assign look_tag         = pc_f[TAG_HI:TAG_LO];
  assign look_hit         = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
  assign predict_taken_f  = look_hit && ctr_q[look_idx][1];
  assign predict_target_f = predict_taken_f ? target_q[look_idx] : '0;
  assign pred_index_f     = look_idx;

  assign upd_tag = update_pc_e[TAG_HI:TAG_LO];
  assign upd_hit = valid_q[update_index_e] && (tag_q[update_index_e] == upd_tag);

  // NOTE: every always_comb output is given a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_en       = 1'b0;
    wr_ctr_d    = ctr_q[update_index_e];
    wr_target_d = target_q[update_index_e];
    if (update_en_e) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        if (update_taken_e) begin
          wr_ctr_d    = sat_inc(ctr_q[update_index_e]);
          wr_target_d = update_target_e;
        end else begin
          wr_ctr_d    = sat_dec(ctr_q[update_index_e]);
        end
      end else if (update_taken_e) begin
        wr_en       = 1'b1;
        wr_ctr_d    = WT;
        wr_target_d = update_target_e;
      end
    end
  end

  // NOTE: the table is a flop array, not a RAM macro, so it can be cleared in one
  // reset cycle; a RAM-based table would instead need a valid-bit sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= BP_CTR_RESET;
      end
    end else if (wr_en) begin
      valid_q[update_index_e]  <= 1'b1;
      tag_q[update_index_e]    <= upd_tag;
      target_q[update_index_e] <= wr_target_d;
      ctr_q[update_index_e]    <= wr_ctr_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor; expected values are
// hand-derived from the counter/BTB rules.
module tb_branch_predictor;

  localparam int XLEN = 32;
  localparam int IB   = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] pc_f;
  logic            predict_taken_f;
  logic [XLEN-1:0] predict_target_f;
  logic [IB-1:0]   pred_index_f;
  logic            update_en_e;
  logic [XLEN-1:0] update_pc_e;
  logic [IB-1:0]   update_index_e;
  logic            update_taken_e;
  logic [XLEN-1:0] update_target_e;

  int n_checks = 0;
  int n_pass   = 0;

  branch_predictor #(.XLEN(XLEN), .INDEX_BITS(IB), .TAG_BITS(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_f             (pc_f),
    .predict_taken_f  (predict_taken_f),
    .predict_target_f (predict_target_f),
    .pred_index_f     (pred_index_f),
    .update_en_e      (update_en_e),
    .update_pc_e      (update_pc_e),
    .update_index_e   (update_index_e),
    .update_taken_e   (update_taken_e),
    .update_target_e  (update_target_e)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IB-1:0] pc_idx(input logic [XLEN-1:0] pc);
    return pc[IB+1:2];
  endfunction

  // Present a lookup PC and compare both prediction outputs.
  task automatic expect_pred(input string tag, input logic [XLEN-1:0] pc,
                             input logic taken, input logic [XLEN-1:0] target);
    pc_f = pc;
    #1;
    check({tag, ".taken"},  {31'd0, predict_taken_f}, {31'd0, taken});
    check({tag, ".target"}, predict_target_f, target);
  endtask

  task automatic set_update(input logic [XLEN-1:0] pc, input logic taken,
                            input logic [XLEN-1:0] target);
    update_en_e     = 1'b1;
    update_pc_e     = pc;
    update_index_e  = pc_idx(pc);
    update_taken_e  = taken;
    update_target_e = target;
  endtask

  task automatic train(input logic [XLEN-1:0] pc, input logic taken,
                       input logic [XLEN-1:0] target);
    set_update(pc, taken, target);
    step();
    update_en_e = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    pc_f            = 32'h100;
    update_en_e     = 1'b0;
    update_pc_e     = '0;
    update_index_e  = '0;
    update_taken_e  = 1'b0;
    update_target_e = '0;
    step();
    step();
    rst = 1'b0;

`ifdef BP_GSHARE_EN
    expect_pred("gs_reset", 32'h100, 1'b0, 32'h0);
    check("gs_idx0", {26'd0, pred_index_f}, 32'h0);
    train(32'h100, 1'b1, 32'h80);
    train(32'h100, 1'b1, 32'h80);
    train(32'h100, 1'b0, 32'h80);
    pc_f = 32'h0;
    #1;
    check("gs_idx_ttn", {26'd0, pred_index_f}, 32'h6);
    pc_f = 32'h104;
    #1;
    check("gs_idx_xor", {26'd0, pred_index_f}, 32'h7);
`else
    // Reset then lookup
    expect_pred("reset", 32'h100, 1'b0, 32'h0);
    check("reset.idx", {26'd0, pred_index_f}, 32'h0);
    pc_f = 32'h104;
    #1;
    check("idx_104", {26'd0, pred_index_f}, 32'h1);

    // Allocate on taken miss; prediction appears only after the edge
    set_update(32'h100, 1'b1, 32'h80);
    expect_pred("alloc_pre", 32'h100, 1'b0, 32'h0);
    step();
    update_en_e = 1'b0;
    expect_pred("alloc", 32'h100, 1'b1, 32'h80);
    expect_pred("alias_tag", 32'h4100, 1'b0, 32'h0);

    // Hysteresis and saturation: WT -N-> WNT -T-> WT -T-> ST -T-> ST -T-> ST
    train(32'h100, 1'b0, 32'h80);
    expect_pred("wt_to_wnt", 32'h100, 1'b0, 32'h0);
    train(32'h100, 1'b1, 32'h80);
    expect_pred("wnt_to_wt", 32'h100, 1'b1, 32'h80);
    train(32'h100, 1'b1, 32'h80);
    train(32'h100, 1'b1, 32'h80);
    train(32'h100, 1'b1, 32'h80);
    expect_pred("st_sat", 32'h100, 1'b1, 32'h80);
    train(32'h100, 1'b0, 32'h80);
    expect_pred("st_to_wt", 32'h100, 1'b1, 32'h80);
    train(32'h100, 1'b0, 32'h80);
    expect_pred("wt_to_wnt2", 32'h100, 1'b0, 32'h0);
    train(32'h100, 1'b1, 32'h90);
    expect_pred("new_target", 32'h100, 1'b1, 32'h90);

    // Not-taken miss on an invalid entry does not allocate
    train(32'h208, 1'b0, 32'h300);
    expect_pred("nt_miss", 32'h208, 1'b0, 32'h0);
    train(32'h208, 1'b1, 32'h300);
    expect_pred("t_alloc2", 32'h208, 1'b1, 32'h300);

    // Taken miss on a valid entry with another tag overwrites it
    train(32'h4100, 1'b1, 32'h44);
    expect_pred("overwrite", 32'h4100, 1'b1, 32'h44);
    expect_pred("evicted", 32'h100, 1'b0, 32'h0);

    // Same-cycle read/write: lookup sees pre-update WT
    train(32'h100, 1'b1, 32'h80);
    set_update(32'h100, 1'b0, 32'h80);
    expect_pred("rdw_same", 32'h100, 1'b1, 32'h80);
    step();
    update_en_e = 1'b0;
    expect_pred("rdw_next", 32'h100, 1'b0, 32'h0);

    // Reset coincident with an update: update dropped, table cleared
    rst = 1'b1;
    set_update(32'h100, 1'b1, 32'h80);
    step();
    rst = 1'b0;
    update_en_e = 1'b0;
    expect_pred("rst_drop", 32'h100, 1'b0, 32'h0);
    expect_pred("rst_clear", 32'h208, 1'b0, 32'h0);
    train(32'h100, 1'b1, 32'h84);
    expect_pred("post_rst", 32'h100, 1'b1, 32'h84);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
